dyn_trunc_scheduler: RTL
========================

# dyn_trunc_scheduler

Block-level controller for the dynamic-truncation datapath in the approximate PE array. It buffers a block of `BLOCK` unsigned operands and OR-accumulates their magnitudes. It then computes one shared truncation select, the MSB position of the block clamped to `MULT_DW`. Finally it replays the buffered operands as `(MULT_DW+1)`-bit truncated words with the select and rescale shift, feeding the reduced-width multiplier input stage.

## Interface
Parameters:
- `BW`, 16: operand width.
- `MULT_DW`, 6: truncated output is `MULT_DW+1` bits.
- `BLOCK`, 8: operands per block sharing one select; must be at least 2.
- `SEL_W`, `$clog2(BW)`: select width (derived).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous active-low reset.
- `in_valid`, in, 1: input operand valid.
- `in_ready`, out, 1: block accepts an operand.
- `in_data`, in, `BW`: unsigned operand.
- `out_valid`, out, 1: truncated word valid.
- `out_ready`, in, 1: consumer accepts the word.
- `out_data`, out, `MULT_DW+1`: equals `buf[rd][sel -: MULT_DW+1]`.
- `out_sel`, out, `SEL_W`: select used for the current block.
- `out_shift`, out, `SEL_W`: `sel - MULT_DW`, the left-shift needed to rescale the product.
- `out_last`, out, 1: marks the final word of the block.

## Operation
- Reset and clock are fixed: one clock `clk`; `rst_n` is asynchronous and active-low.
- FSM states: `FILL`, `SELECT`, `DRAIN`.
- **FILL**
  - `in_ready` = 1.
  - On each `in_valid & in_ready`: `buf[wr_cnt] <= in_data`, `acc <= acc | in_data`, `wr_cnt++`.
  - When the transfer with `wr_cnt == BLOCK-1` occurs, go to `SELECT`.
- **SELECT** (one cycle)
  - `in_ready` = 0.
  - `p` = index of the highest set bit of `acc`.
  - `sel_q <= (acc == 0 || p < MULT_DW) ? MULT_DW : p`.
  - Clear `acc`, clear `rd_cnt`, go to `DRAIN`.
- **DRAIN**
  - `out_valid` = 1 and `in_ready` = 0; `in_valid` is ignored.
  - `out_data`, `out_sel` and `out_shift` are held stable until `out_valid & out_ready`, which increments `rd_cnt`.
  - `out_last` = (`rd_cnt == BLOCK-1`).
  - The transfer with `out_last` clears `wr_cnt` and returns the FSM to `FILL`.
- Width rules:
  - `sel_q` always lies in `[MULT_DW, BW-1]`, so the part-select is never out of range.
  - `out_shift` lies in `[0, BW-1-MULT_DW]`.
  - `sel_q` never changes during `DRAIN`.
- Outputs when `out_valid` = 0: `out_data` = 0 and `out_last` = 0. `out_sel` and `out_shift` hold the last block's values.
- Reset (asserted at any time, including mid-`FILL` or mid-`DRAIN`) forces:
  - state = `FILL`; `wr_cnt`, `rd_cnt`, `acc` = 0; `sel_q` = `MULT_DW`.
  - A partial block is discarded; buffer contents are don't-care.
- Output values during and right after reset:
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_last` = 0.
  - `out_sel` = `MULT_DW`, `out_shift` = 0.

## Timing
- Latency: last input accepted at edge t; `SELECT` occupies cycle t+1; the first `out_valid` is high in cycle t+2.
- Minimum period per block is `2*BLOCK + 1` cycles, reached with continuous valid and ready. With `out_ready` = 1, `in_ready` is low for exactly `BLOCK+1` cycles per block.
- `in_ready` and `out_valid` are decoded from registered state only; neither combinationally depends on `in_valid` or `out_ready`.
- The `out_data` mux is combinational from `buf[rd_cnt]` and `sel_q`. The critical path is the `BW:1` select mux plus the buffer read.

## Structure
- Package `dt_pkg` holds:
  - the state enum (`FILL`, `SELECT`, `DRAIN`);
  - a function `dt_sel_w(bw)`;
  - a function `dt_clamp_sel(p, mult_dw)`.
- Sub-module `dt_lod`: parameterised `BW`-bit leading-one detector with outputs `pos[SEL_W-1:0]` and `zero`. It is used in `SELECT`.
- The buffer is a register array of depth `BLOCK`; no memory macro is used.

## Test plan
All scenarios use `BW`=16, `MULT_DW`=6, `BLOCK`=4.
- Block {0x0003, 0x0010, 0x0041, 0x0000} -> `sel` = 6, `shift` = 0, `out_data` = 0x03, 0x10, 0x41, 0x00; `out_last` only on the 4th word.
- Block {0x1234, 0x0001, 0x8000, 0x00FF} -> `sel` = 15, `shift` = 9, `out_data` = 0x09, 0x00, 0x40, 0x00.
- All-zero block -> `sel` = 6, `shift` = 0, every `out_data` = 0.
- Backpressure: `out_ready` pattern 1,0,1,0 repeated -> each word is held stable while stalled; `in_ready` stays 0 throughout `DRAIN`; `in_valid` pulses during `DRAIN` are not captured.
- `rst_n` pulsed low after 2 of 4 words drained -> `out_valid` = 0 and `in_ready` = 1 immediately. The next block, {0x0100 ×4}, yields `sel` = 8 and `out_data` = 0x40 ×4, with no leftover bits in `acc`.
- Continuous `in_valid` and `out_ready` over 3 blocks -> first output 2 cycles after the 4th input, period 9 cycles; each block's `sel` is independent of the previous block's.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared types and helpers for the dynamic-truncation scheduler.
package dt_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SELECT = 2'd1,
        DRAIN  = 2'd2
    } dt_state_e;

    // Width needed to hold a bit position inside a bw-bit operand.
    function automatic int dt_sel_w(input int bw);
        return (bw <= 2) ? 1 : $clog2(bw);
    endfunction

    // Never select below the truncated word width, so the part-select stays in range.
    function automatic int dt_clamp_sel(input int p, input int mult_dw);
        return (p < mult_dw) ? mult_dw : p;
    endfunction

endpackage

// File: rtl/dt_lod.sv
// Leading-one detector: position of the highest set bit, plus an all-zero flag.
module dt_lod
    import dt_pkg::*;
#(
    parameter int BW    = 16,
    parameter int SEL_W = dt_sel_w(BW)
) (
    input  logic [BW-1:0]    data,
    output logic [SEL_W-1:0] pos,
    output logic             zero
);

    // Scan upward so the last hit is the most significant set bit.
    always_comb begin
        pos = '0;
        for (int i = 0; i < BW; i++) begin
            if (data[i]) pos = SEL_W'(i);
        end
    end

    assign zero = ~|data;

endmodule

// File: rtl/dyn_trunc_scheduler.sv
// Block-level truncation controller: buffer a block, pick one shared MSB select,
// then replay the block as reduced-width words with the select and rescale shift.
module dyn_trunc_scheduler
    import dt_pkg::*;
#(
    parameter int BW      = 16,
    parameter int MULT_DW = 6,
    parameter int BLOCK   = 8,
    parameter int SEL_W   = dt_sel_w(BW)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BW-1:0]      in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [MULT_DW:0]   out_data,
    output logic [SEL_W-1:0]   out_sel,
    output logic [SEL_W-1:0]   out_shift,
    output logic               out_last
);

    localparam int CNT_W = $clog2(BLOCK);

    dt_state_e                  state;
    logic [CNT_W-1:0]           wr_cnt;
    logic [CNT_W-1:0]           rd_cnt;
    logic [BW-1:0]              acc;
    logic [SEL_W-1:0]           sel_q;
    logic [BLOCK-1:0][BW-1:0]   buf_q;

    logic [SEL_W-1:0]           lod_pos;
    logic                       lod_zero;
    logic                       in_fire;
    logic                       out_fire;
    logic [BW-1:0]              rd_word;
    logic [BW-1:0]              rd_shifted;

    dt_lod #(.BW(BW), .SEL_W(SEL_W)) u_lod (
        .data (acc),
        .pos  (lod_pos),
        .zero (lod_zero)
    );

    // Handshakes decode from registered state only.
    assign in_ready  = (state == FILL);
    assign out_valid = (state == DRAIN);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Shifting right by (sel - MULT_DW) and keeping the low bits is buf[sel -: MULT_DW+1].
    assign out_sel    = sel_q;
    assign out_shift  = sel_q - SEL_W'(MULT_DW);
    assign rd_word    = buf_q[rd_cnt];
    assign rd_shifted = rd_word >> out_shift;
    assign out_data   = out_valid ? rd_shifted[MULT_DW:0] : '0;
    assign out_last   = out_valid && (rd_cnt == CNT_W'(BLOCK - 1));

    // Operand buffer needs no reset: a partial block is simply overwritten.
    always_ff @(posedge clk) begin
        if (in_fire) buf_q[wr_cnt] <= in_data;
    end

    // Block sequencing: FILL accumulates, SELECT latches the select, DRAIN replays.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FILL;
            wr_cnt <= '0;
            rd_cnt <= '0;
            acc    <= '0;
            sel_q  <= SEL_W'(MULT_DW);
        end else begin
            case (state)
                FILL: begin
                    if (in_fire) begin
                        acc    <= acc | in_data;
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == CNT_W'(BLOCK - 1)) state <= SELECT;
                    end
                end
                SELECT: begin
                    sel_q  <= lod_zero ? SEL_W'(MULT_DW)
                                       : SEL_W'(dt_clamp_sel(int'(lod_pos), MULT_DW));
                    acc    <= '0;
                    rd_cnt <= '0;
                    state  <= DRAIN;
                end
                DRAIN: begin
                    if (out_fire) begin
                        rd_cnt <= rd_cnt + 1'b1;
                        if (out_last) begin
                            wr_cnt <= '0;
                            rd_cnt <= '0;
                            state  <= FILL;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule
